// File: rtl/rate_divided_counter.sv
// rate_divided_counter
//   Hex digit counter whose advance rate is chosen by a down-counting clock
//   divider. The digit feeds a 7-segment decoder.
//
//   Parameter CLK_FREQ : clock cycles per second (divider base).
//   Optional feature   : define LOAD_EN to add the parallel-load port pair.
//
//   Ports
//     clock   in   sole clock, rising edge
//     resetn  in   asynchronous active-low reset
//     enable  in   count enable; low freezes divider and digit
//     speed   in   [1:0] rate: 00 every cycle, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz
//     load    in   parallel-load strobe (LOAD_EN only)
//     d       in   [3:0] parallel-load value (LOAD_EN only)
//     q       out  [3:0] current hex digit
//     tick    out  one-cycle pulse when q advances from counting
//     wrap    out  one-cycle pulse when q advances F->0 from counting
module rate_divided_counter #(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic [1:0] speed,
`ifdef LOAD_EN
  input  logic       load,
  input  logic [3:0] d,
`endif
  output logic [3:0] q,
  output logic       tick,
  output logic       wrap
);

  localparam int unsigned RD_W = $clog2(4 * CLK_FREQ);

  localparam logic [RD_W-1:0] RELOAD_1HZ  = RD_W'(CLK_FREQ - 1);
  localparam logic [RD_W-1:0] RELOAD_HALF = RD_W'(2 * CLK_FREQ - 1);
  localparam logic [RD_W-1:0] RELOAD_QTR  = RD_W'(4 * CLK_FREQ - 1);

  function automatic logic [RD_W-1:0] reload(input logic [1:0] s);
    case (s)
      2'b00:   return '0;
      2'b01:   return RELOAD_1HZ;
      2'b10:   return RELOAD_HALF;
      default: return RELOAD_QTR;
    endcase
  endfunction

  logic [RD_W-1:0] rd_q, rd_d;
  logic [3:0]      q_q, q_d;
  logic [1:0]      speed_r_q, speed_r_d;
  logic            tick_q, tick_d;
  logic            wrap_q, wrap_d;
  logic            load_w;
  logic [3:0]      load_val;

`ifdef LOAD_EN
  assign load_w   = load;
  assign load_val = d;
`else
  assign load_w   = 1'b0;
  assign load_val = '0;
`endif

  // Priority: load, then speed change (regardless of enable), then count.
  always_comb begin
    rd_d      = rd_q;
    q_d       = q_q;
    speed_r_d = speed_r_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    if (load_w) begin
      q_d       = load_val;
      rd_d      = reload(speed);
      speed_r_d = speed;
    end else if (speed != speed_r_q) begin
      rd_d      = reload(speed);
      speed_r_d = speed;
    end else if (enable) begin
      if (rd_q == '0) begin
        q_d    = q_q + 4'd1;
        rd_d   = reload(speed_r_q);
        tick_d = 1'b1;
        wrap_d = (q_q == 4'hF);
      end else begin
        rd_d = rd_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_q      <= '0;
      q_q       <= '0;
      speed_r_q <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      rd_q      <= rd_d;
      q_q       <= q_d;
      speed_r_q <= speed_r_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  assign q    = q_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

`ifndef LOAD_EN
  logic unused_load;
  assign unused_load = ^{load_w, load_val};
`endif

endmodule
